// File: rtl/spie_periph_rxtx.sv
// SPI peripheral (slave) receiver/transmitter, CPOL=1/CPHA=1, 8/16/32-bit words,
// MSByte- or LSByte-first, oversampled in the clk domain.
module spie_periph_rxtx #(
   parameter int unsigned sync_stages = 2,
   parameter logic [31:0] idle_word   = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        msbytefirst,
   input  logic [1:0]  datawidth,
   input  logic [31:0] data_tx,
   input  logic        tx_wr,
   output logic        tx_empty,
   output logic        tx_underrun,
   output logic [31:0] data_rx,
   output logic        rx_rdy,
   input  logic        rx_ack,
   output logic        rx_overrun,
   output logic        busy,
   input  logic        sclk_in,
   input  logic        mosi_in,
   input  logic        cs_n_in,
   output logic        miso,
   output logic        miso_oe
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [1:0] W8  = 2'd0;
   localparam logic [1:0] W16 = 2'd1;
   localparam logic [1:0] W32 = 2'd2;

   function automatic logic [1:0] decode_width(input logic [1:0] dw);
      case (dw)
         2'b10:   return W16;
         2'b01:   return W32;
         default: return W8;
      endcase
   endfunction

   function automatic logic [4:0] last_bit(input logic [1:0] ws);
      case (ws)
         W16:     return 5'd15;
         W32:     return 5'd31;
         default: return 5'd7;
      endcase
   endfunction

   function automatic logic [31:0] byte_swap(input logic [31:0] x, input logic [1:0] ws);
      case (ws)
         W16:     return {16'h0000, x[7:0], x[15:8]};
         W32:     return {x[7:0], x[15:8], x[23:16], x[31:24]};
         default: return {24'h00_0000, x[7:0]};
      endcase
   endfunction

   // Word image inside the shift register is always MSbit-first over W bits;
   // LSByte-first order is obtained by swapping bytes on load and on capture.
   function automatic logic [31:0] wire_order(input logic [31:0] x, input logic [1:0] ws,
                                              input logic msb);
      logic [31:0] m;
      case (ws)
         W16:     m = 32'h0000_FFFF;
         W32:     m = 32'hFFFF_FFFF;
         default: m = 32'h0000_00FF;
      endcase
      return msb ? (x & m) : byte_swap(x, ws);
   endfunction

   state_t state_q, state_d;
   logic [sync_stages-1:0] sclk_sync_q, sclk_sync_d;
   logic [sync_stages-1:0] mosi_sync_q, mosi_sync_d;
   logic [sync_stages-1:0] cs_n_sync_q, cs_n_sync_d;
   logic        sclk_prev_q, sclk_prev_d;
   logic [31:0] tx_buf_q, tx_buf_d;
   logic        tx_empty_q, tx_empty_d;
   logic        tx_underrun_q, tx_underrun_d;
   logic [31:0] tx_sh_q, tx_sh_d;
   logic [30:0] rx_sh_q, rx_sh_d;
   logic [31:0] data_rx_q, data_rx_d;
   logic        rx_rdy_q, rx_rdy_d;
   logic        rx_overrun_q, rx_overrun_d;
   logic [4:0]  bitcnt_q, bitcnt_d;
   logic        word_done_q, word_done_d;
   logic        sampled_q, sampled_d;
   logic [1:0]  wsel_q, wsel_d;
   logic        msb_q, msb_d;

   logic        sclk_s, mosi_s, cs_n_s, rise, fall, load;
   logic [31:0] rx_new, load_src;

   assign sclk_s = sclk_sync_q[sync_stages-1];
   assign mosi_s = mosi_sync_q[sync_stages-1];
   assign cs_n_s = cs_n_sync_q[sync_stages-1];
   assign rise   = sclk_s & ~sclk_prev_q;
   assign fall   = ~sclk_s & sclk_prev_q;

   always_comb begin
      state_d       = state_q;
      sclk_sync_d   = {sclk_sync_q[sync_stages-2:0], sclk_in};
      mosi_sync_d   = {mosi_sync_q[sync_stages-2:0], mosi_in};
      cs_n_sync_d   = {cs_n_sync_q[sync_stages-2:0], cs_n_in};
      sclk_prev_d   = sclk_s;
      tx_buf_d      = tx_buf_q;
      tx_empty_d    = tx_empty_q;
      tx_underrun_d = tx_underrun_q;
      tx_sh_d       = tx_sh_q;
      rx_sh_d       = rx_sh_q;
      data_rx_d     = data_rx_q;
      rx_rdy_d      = rx_rdy_q;
      rx_overrun_d  = rx_overrun_q;
      bitcnt_d      = bitcnt_q;
      word_done_d   = word_done_q;
      sampled_d     = sampled_q;
      wsel_d        = wsel_q;
      msb_d         = msb_q;
      load          = 1'b0;
      rx_new        = {rx_sh_q, mosi_s};
      load_src      = tx_buf_q;

      if (rx_ack) begin
         rx_rdy_d     = 1'b0;
         rx_overrun_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!cs_n_s) begin
               state_d     = SHIFT;
               wsel_d      = decode_width(datawidth);
               msb_d       = msbytefirst;
               load        = 1'b1;
               bitcnt_d    = 5'd0;
               word_done_d = 1'b0;
               sampled_d   = 1'b0;
            end
         end
         SHIFT: begin
            if (cs_n_s) begin
               state_d     = IDLE;
               bitcnt_d    = 5'd0;
               word_done_d = 1'b0;
               sampled_d   = 1'b0;
            end else if (rise) begin
               rx_sh_d   = rx_new[30:0];
               sampled_d = 1'b1;
               if (bitcnt_q == last_bit(wsel_q)) begin
                  data_rx_d   = wire_order(rx_new, wsel_q, msb_q);
                  rx_rdy_d    = 1'b1;
                  // Completion beats a same-cycle ack; overrun only if the old word was unread.
                  if (rx_rdy_q && !rx_ack) rx_overrun_d = 1'b1;
                  bitcnt_d    = 5'd0;
                  word_done_d = 1'b1;
               end else begin
                  bitcnt_d = bitcnt_q + 5'd1;
               end
            end else if (fall) begin
               // A falling edge only advances MISO after the master has sampled a bit.
               if (word_done_q) begin
                  load        = 1'b1;
                  word_done_d = 1'b0;
               end else if (sampled_q) begin
                  tx_sh_d = {tx_sh_q[30:0], 1'b1};
               end
               sampled_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (tx_wr) tx_underrun_d = 1'b0;

      if (load) begin
         if (tx_empty_q) begin
            load_src      = idle_word;
            tx_underrun_d = 1'b1;
         end
         tx_sh_d    = wire_order(load_src, wsel_d, msb_d);
         tx_empty_d = 1'b1;
      end

      // A write coinciding with a load refills the buffer after the old word was taken.
      if (tx_wr) begin
         tx_buf_d   = data_tx;
         tx_empty_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         sclk_sync_q   <= '1;
         mosi_sync_q   <= '1;
         cs_n_sync_q   <= '1;
         sclk_prev_q   <= 1'b1;
         tx_buf_q      <= 32'h0;
         tx_empty_q    <= 1'b1;
         tx_underrun_q <= 1'b0;
         tx_sh_q       <= 32'hFFFF_FFFF;
         rx_sh_q       <= 31'h0;
         data_rx_q     <= 32'h0;
         rx_rdy_q      <= 1'b0;
         rx_overrun_q  <= 1'b0;
         bitcnt_q      <= 5'd0;
         word_done_q   <= 1'b0;
         sampled_q     <= 1'b0;
         wsel_q        <= W8;
         msb_q         <= 1'b1;
      end else begin
         state_q       <= state_d;
         sclk_sync_q   <= sclk_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         cs_n_sync_q   <= cs_n_sync_d;
         sclk_prev_q   <= sclk_prev_d;
         tx_buf_q      <= tx_buf_d;
         tx_empty_q    <= tx_empty_d;
         tx_underrun_q <= tx_underrun_d;
         tx_sh_q       <= tx_sh_d;
         rx_sh_q       <= rx_sh_d;
         data_rx_q     <= data_rx_d;
         rx_rdy_q      <= rx_rdy_d;
         rx_overrun_q  <= rx_overrun_d;
         bitcnt_q      <= bitcnt_d;
         word_done_q   <= word_done_d;
         sampled_q     <= sampled_d;
         wsel_q        <= wsel_d;
         msb_q         <= msb_d;
      end
   end

   assign tx_empty    = tx_empty_q;
   assign tx_underrun = tx_underrun_q;
   assign data_rx     = data_rx_q;
   assign rx_rdy      = rx_rdy_q;
   assign rx_overrun  = rx_overrun_q;
   assign busy        = ~cs_n_s;
   assign miso_oe     = busy;
   assign miso        = (state_q == SHIFT) ? tx_sh_q[last_bit(wsel_q)] : 1'b1;

endmodule

// File: tb/tb_spie_periph_rxtx.sv
// Bench for spie_periph_rxtx: behavioural SPI master (CPOL=1/CPHA=1) plus a
// queue-based monitor for received words on both sides.
module tb_spie_periph_rxtx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        msbytefirst = 1'b1;
   logic [1:0]  datawidth = 2'b00;
   logic [31:0] data_tx = 32'h0;
   logic        tx_wr = 1'b0;
   logic        tx_empty, tx_underrun;
   logic [31:0] data_rx;
   logic        rx_rdy;
   logic        rx_ack = 1'b0;
   logic        rx_overrun, busy;
   logic        sclk_in = 1'b1;
   logic        mosi_in = 1'b1;
   logic        cs_n_in = 1'b1;
   logic        miso, miso_oe;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_miso_q[$];
   logic [31:0] got_miso_q[$];
   logic [31:0] exp_rx_q[$];
   logic        exp_ovr_q[$];

   spie_periph_rxtx dut (
      .clk(clk), .rst(rst), .msbytefirst(msbytefirst), .datawidth(datawidth),
      .data_tx(data_tx), .tx_wr(tx_wr), .tx_empty(tx_empty), .tx_underrun(tx_underrun),
      .data_rx(data_rx), .rx_rdy(rx_rdy), .rx_ack(rx_ack), .rx_overrun(rx_overrun),
      .busy(busy), .sclk_in(sclk_in), .mosi_in(mosi_in), .cs_n_in(cs_n_in),
      .miso(miso), .miso_oe(miso_oe)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tx_write(input logic [31:0] w);
      @(posedge clk); #1 data_tx = w; tx_wr = 1'b1;
      @(posedge clk); #1 tx_wr = 1'b0;
   endtask

   task automatic ack();
      @(posedge clk); #1 rx_ack = 1'b1;
      @(posedge clk); #1 rx_ack = 1'b0;
   endtask

   // Master: byte j travels in order (LSByte mode: byte 0 first), MSbit first in each byte.
   // MOSI changes on the falling edge; MISO is captured at the end of the high phase.
   task automatic master_xfer(input logic [31:0] w0, input logic [31:0] w1, input int nwords,
                              input int nbits, input bit lsb, input int stop_after);
      logic [31:0] mo, got;
      int j, idx, sent;
      sent = 0;
      cs_n_in = 1'b0;
      #100;
      for (int w = 0; w < nwords; w++) begin
         mo  = (w == 0) ? w0 : w1;
         got = 32'h0;
         for (int k = 0; k < nbits; k++) begin
            if (stop_after == 0 || sent < stop_after) begin
               j   = lsb ? (k / 8) : (nbits / 8 - 1 - k / 8);
               idx = j * 8 + 7 - (k % 8);
               sclk_in = 1'b0; mosi_in = mo[idx];
               #50 sclk_in = 1'b1;
               #49 got[idx] = miso;
               #1 sent++;
            end
         end
         if (stop_after == 0) got_miso_q.push_back(got);
      end
      cs_n_in = 1'b1;
      mosi_in = 1'b1;
      #200;
   endtask

   // Monitor: a new word is presented when rx_rdy rises or rx_overrun rises.
   logic prev_rdy = 1'b0;
   logic prev_ovr = 1'b0;
   always @(negedge clk) begin
      if (!rst && rx_rdy && (!prev_rdy || (rx_overrun && !prev_ovr))) begin
         if (exp_rx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rx_unexpected: got data_rx=%h with no word expected", data_rx);
         end else begin
            chk("rx_data", data_rx, exp_rx_q.pop_front());
            chk("rx_overrun", {31'h0, rx_overrun}, {31'h0, exp_ovr_q.pop_front()});
         end
      end
      prev_rdy = rx_rdy;
      prev_ovr = rx_overrun;
      if (got_miso_q.size() != 0) begin
         if (exp_miso_q.size() == 0) begin
            total++; bad++;
            $display("FAIL miso_unexpected: got %h with no word expected", got_miso_q.pop_front());
         end else begin
            chk("miso_word", got_miso_q.pop_front(), exp_miso_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200 us");
      $fatal(1, "watchdog");
   end

   initial begin
      #35;
      chk("rst_tx_empty", {31'h0, tx_empty}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_miso", {31'h0, miso}, 32'h1);
      chk("rst_rx_rdy", {31'h0, rx_rdy}, 32'h0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("init_data_rx", data_rx, 32'h0);
      chk("init_underrun", {31'h0, tx_underrun}, 32'h0);

      // 8-bit, MSByte first
      datawidth = 2'b00; msbytefirst = 1'b1;
      tx_write(32'h0000_00A5);
      chk("tx_not_empty", {31'h0, tx_empty}, 32'h0);
      exp_miso_q.push_back(32'h0000_00A5);
      exp_rx_q.push_back(32'h0000_003C); exp_ovr_q.push_back(1'b0);
      master_xfer(32'h3C, 32'h0, 1, 8, 1'b0, 0);
      chk("t1_rx_rdy", {31'h0, rx_rdy}, 32'h1);
      chk("t1_tx_empty", {31'h0, tx_empty}, 32'h1);
      ack();
      #1 chk("t1_ack_rdy", {31'h0, rx_rdy}, 32'h0);

      // 32-bit, LSByte first then MSByte first
      datawidth = 2'b01; msbytefirst = 1'b0;
      tx_write(32'h1122_3344);
      exp_miso_q.push_back(32'h1122_3344);
      exp_rx_q.push_back(32'hDEAD_BEEF); exp_ovr_q.push_back(1'b0);
      master_xfer(32'hDEAD_BEEF, 32'h0, 1, 32, 1'b1, 0);
      ack();
      msbytefirst = 1'b1;
      tx_write(32'h1122_3344);
      exp_miso_q.push_back(32'h1122_3344);
      exp_rx_q.push_back(32'hDEAD_BEEF); exp_ovr_q.push_back(1'b0);
      master_xfer(32'hDEAD_BEEF, 32'h0, 1, 32, 1'b0, 0);
      ack();

      // Back-to-back 16-bit, second TX written during word 1, no ack between words
      datawidth = 2'b10; msbytefirst = 1'b1;
      tx_write(32'h0000_0102);
      exp_miso_q.push_back(32'h0000_0102);
      exp_miso_q.push_back(32'h0000_0304);
      exp_rx_q.push_back(32'h0000_AAAA); exp_ovr_q.push_back(1'b0);
      exp_rx_q.push_back(32'h0000_5555); exp_ovr_q.push_back(1'b1);
      fork
         master_xfer(32'h0000_AAAA, 32'h0000_5555, 2, 16, 1'b0, 0);
         begin #600; tx_write(32'h0000_0304); end
      join
      chk("t3_overrun", {31'h0, rx_overrun}, 32'h1);
      chk("t3_tx_empty", {31'h0, tx_empty}, 32'h1);
      ack();
      #1 chk("t3_ack_ovr", {31'h0, rx_overrun}, 32'h0);

      // Empty TX buffer at select: idle word goes out, underrun flags
      datawidth = 2'b00;
      exp_miso_q.push_back(32'h0000_00FF);
      exp_rx_q.push_back(32'h0000_0081); exp_ovr_q.push_back(1'b0);
      master_xfer(32'h81, 32'h0, 1, 8, 1'b0, 0);
      chk("t4_underrun", {31'h0, tx_underrun}, 32'h1);
      ack();
      tx_write(32'h0000_0000);
      chk("t4_underrun_clr", {31'h0, tx_underrun}, 32'h0);

      // Abort after 5 of 8 bits, then a full transfer
      master_xfer(32'hF0, 32'h0, 1, 8, 1'b0, 5);
      chk("t5_rx_rdy", {31'h0, rx_rdy}, 32'h0);
      chk("t5_miso", {31'h0, miso}, 32'h1);
      chk("t5_busy", {31'h0, busy}, 32'h0);
      tx_write(32'h0000_005A);
      exp_miso_q.push_back(32'h0000_005A);
      exp_rx_q.push_back(32'h0000_00C3); exp_ovr_q.push_back(1'b0);
      master_xfer(32'hC3, 32'h0, 1, 8, 1'b0, 0);
      chk("t5_rx_rdy_full", {31'h0, rx_rdy}, 32'h1);

      // Asynchronous reset in the middle of a word
      tx_write(32'h0000_0077);
      fork
         master_xfer(32'h0F, 32'h0, 1, 8, 1'b0, 4);
         begin
            #300;
            @(posedge clk);
            #3 rst = 1'b1;
            #1;
            chk("ar_tx_empty", {31'h0, tx_empty}, 32'h1);
            chk("ar_underrun", {31'h0, tx_underrun}, 32'h0);
            chk("ar_data_rx", data_rx, 32'h0);
            chk("ar_rx_rdy", {31'h0, rx_rdy}, 32'h0);
            chk("ar_overrun", {31'h0, rx_overrun}, 32'h0);
            chk("ar_busy", {31'h0, busy}, 32'h0);
            chk("ar_miso", {31'h0, miso}, 32'h1);
            chk("ar_miso_oe", {31'h0, miso_oe}, 32'h0);
         end
      join
      #100 rst = 1'b0;
      repeat (4) @(posedge clk);

      chk("pending_miso", exp_miso_q.size(), 32'h0);
      chk("pending_rx", exp_rx_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spie_periph_rxtx.md
Name: spie_periph_rxtx

Overview:
- SPI peripheral-side (slave) receiver/transmitter; the counterpart of our SPI master engine.
- Lets an on-chip or FPGA-hosted peripheral answer the master with the same data-width and byte-order options: 8/16/32 bits, MSByte-first or LSByte-first.
- Samples the external SCLK/MOSI/CS_N in the system clock domain and drives MISO.
- Exposes a buffered TX word and an RX holding register with ready and overrun flags to the local bus.

Parameters:
- sync_stages, 2: synchroniser depth for sclk_in, mosi_in and cs_n_in (≥2).
- idle_word, 32'hFFFF_FFFF: word shifted out when the TX buffer is empty at load time.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- msbytefirst  in  1  1 = MSByte first, 0 = LSByte (byte 0) first; MSbit first within each byte in both cases
- datawidth  in  2  2'b00 = 8, 2'b10 = 16, 2'b01 = 32 bits; 2'b11 treated as 8
- data_tx  in  32  word for the TX buffer
- tx_wr  in  1  one-cycle strobe; writes data_tx into the TX buffer
- tx_empty  out  1  TX buffer free
- tx_underrun  out  1  sticky: idle_word was sent; cleared by tx_wr
- data_rx  out  32  RX holding register, zero-extended to the selected width
- rx_rdy  out  1  word available in data_rx
- rx_ack  in  1  one-cycle strobe; clears rx_rdy and rx_overrun
- rx_overrun  out  1  sticky: a word completed while rx_rdy was still 1
- busy  out  1  cs_n synchronised low
- sclk_in  in  1  SPI clock from master; idles high
- mosi_in  in  1  master data
- cs_n_in  in  1  chip select, active-low
- miso  out  1  peripheral data; 1 when deselected (not tri-stated here)
- miso_oe  out  1  equals busy, for an external tri-state driver

Behaviour:
- Reset values (asynchronous): tx_empty=1, tx_underrun=0, data_rx=0, rx_rdy=0, rx_overrun=0, busy=0, miso=1, shift register = all ones, bit counter = 0, synchroniser flops = 1.
- Mode: CPOL=1, CPHA=1.
  - MOSI is sampled on the SCLK rising edge.
  - MISO advances on the SCLK falling edge.
  - The first MISO bit is valid from CS_N assertion.
- Synchronisation and edge detection:
  - sclk, mosi and cs_n all pass through sync_stages flops.
  - Edges are detected on the synchronised sclk (current vs previous sample); mosi is taken from the same pipeline stage as the edge.
- Clock ratio: clk must be ≥ 4× SCLK, i.e. each SCLK phase spans ≥ 2 clk cycles. Behaviour below that ratio is undefined.
- States: IDLE, SHIFT.
- CS_N falling edge (IDLE→SHIFT):
  - Load the shift register from the TX buffer and set tx_empty=1.
  - If tx_empty was already 1, load idle_word instead and set tx_underrun.
  - Clear the bit counter.
- Rising edge in SHIFT:
  - Shift the synchronised MOSI in.
  - If bitcnt equals W−1 (W = 8/16/32): word complete. Copy the masked received word to data_rx, set rx_rdy, set rx_overrun if rx_rdy was already 1 (new data overwrites), clear bitcnt.
  - Otherwise increment bitcnt.
- Falling edge in SHIFT:
  - Shift out the next bit.
  - If the preceding rising edge completed a word, reload the shift register from the TX buffer (same empty/underrun rule) instead of shifting. This supports back-to-back words under one CS_N.
- Bit order:
  - msbytefirst=1: plain MSbit-first shift over W bits. MISO = bit W−1. Received bits enter at bit 0.
  - msbytefirst=0: bytes travel byte 0 first, then byte 1, and so on; MSbit first within each byte. MISO = bit 7 of the current byte. Received bytes land in byte 0 first. The result must equal what the master's LSByte-first mode produces.
- CS_N rising edge (SHIFT→IDLE):
  - Abort any partial word: no rx_rdy, partial bits discarded.
  - Drive miso=1 and clear bitcnt.
  - An unconsumed TX load is not restored.
- tx_wr while busy updates only the buffer; it never affects the active shift register. tx_wr while tx_empty=0 overwrites the buffer.
- Simultaneous events:
  - rx_ack in the same cycle as a word completion: completion wins. rx_rdy stays 1 and rx_overrun is not set.
  - tx_wr in the same cycle as a load: the load takes the old buffer content and tx_empty remains 0 with the new word.
- datawidth and msbytefirst must be stable while busy; changes take effect at the next CS_N assertion.

Test Plan:
- 8-bit, msbytefirst=1: tx_wr 8'hA5, master sends 8'h3C at 10 MHz with clk = 50 MHz → master receives 8'hA5; data_rx=32'h0000_003C; rx_rdy=1; tx_empty=1.
- 32-bit, msbytefirst=0: TX 32'h1122_3344, master sends 32'hDEAD_BEEF in its LSByte-first mode → master reads 32'h1122_3344, data_rx=32'hDEAD_BEEF; repeat with msbytefirst=1 and the same values.
- Back-to-back 16-bit:
  - Write 16'h0102, start the transfer, write 16'h0304 during word 1.
  - Expect MISO words 0x0102 then 0x0304.
  - After word 1, no rx_ack → after word 2, rx_overrun=1 and data_rx = second word.
- Empty TX at CS_N assertion → MISO returns idle_word bits (all ones) and tx_underrun=1; a subsequent tx_wr clears it.
- CS_N deasserted after 5 of 8 bits → rx_rdy stays 0, miso=1, busy=0. The next full transfer receives correctly.
- Assert rst mid-word → all outputs immediately return to their reset values, with no clock edge required.
